// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: sink-side VGA decoder and timing checker.
// Recovers pixel coordinates from the HS/VS sync edges, checks line and frame
// lengths, counts pure-red and pure-green visible pixels per frame and runs a
// lock state machine that declares the stream stable after LOCK_FRAMES good
// frames.
//
// Ports:
//   clk25        pixel clock
//   reset        synchronous, active-high
//   HS, VS       horizontal / vertical sync (polarity set by SYNC_ACTIVE_LOW)
//   r, g, b      4-bit colour components
//   px_x, px_y   recovered coordinate of the current visible pixel (0 otherwise)
//   pxValid      px_x/px_y describe a visible pixel
//   insideHits   red pixels in the last completed frame
//   outsideHits  green pixels in the last completed frame
//   frameDone    one-cycle pulse when a frame closes
//   frameValid   last closed frame had correct timing
//   locked       timing locked
//   hErr         one-cycle pulse on a bad line length
//   vErr         one-cycle pulse on a bad frame length
module vga_frame_monitor #(
    parameter int H_VIS           = 32'd640,
    parameter int H_SYNC          = 32'd96,
    parameter int H_BP            = 32'd48,
    parameter int H_TOTAL         = 32'd800,
    parameter int V_VIS           = 32'd480,
    parameter int V_SYNC          = 32'd2,
    parameter int V_BP            = 32'd33,
    parameter int V_TOTAL         = 32'd525,
    parameter int SYNC_ACTIVE_LOW = 32'd1,
    parameter int LOCK_FRAMES     = 32'd2,
    parameter int COUNT_W         = 32'd19
) (
    input  logic               clk25,
    input  logic               reset,
    input  logic               HS,
    input  logic               VS,
    input  logic [3:0]         r,
    input  logic [3:0]         g,
    input  logic [3:0]         b,
    output logic [9:0]         px_x,
    output logic [9:0]         px_y,
    output logic               pxValid,
    output logic [COUNT_W-1:0] insideHits,
    output logic [COUNT_W-1:0] outsideHits,
    output logic               frameDone,
    output logic               frameValid,
    output logic               locked,
    output logic               hErr,
    output logic               vErr
);

    localparam logic SYNC_ACT = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam int   X_FIRST  = H_SYNC + H_BP;
    localparam int   X_LAST   = X_FIRST + H_VIS - 1;
    localparam int   Y_FIRST  = V_SYNC + V_BP;
    localparam int   Y_LAST   = Y_FIRST + V_VIS - 1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    // Position counters stick at their maximum when sync stops toggling.
    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        if (v == 10'h3FF) begin
            return v;
        end else begin
            return v + 10'd1;
        end
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc_cnt(input logic [COUNT_W-1:0] v);
        if (v == {COUNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Syncs are stored normalised to "1 = asserted" so that a cleared history
    // means "inactive" and the first assertion after reset is seen as an edge.
    logic               hs_s1_r, vs_s1_r;
    logic               hs_prev_r, vs_prev_r;
    logic [3:0]         r_s1_r, g_s1_r, b_s1_r;
    logic [9:0]         h_cnt_r, v_cnt_r;
    logic               h_seen_r, v_seen_r;
    logic               frame_err_r;
    logic [COUNT_W-1:0] run_in_r, run_out_r;
    lock_state_t        state_r;
    logic [7:0]         acq_cnt_r;

    logic        hs_edge_s, vs_edge_s;
    logic [10:0] h_inc_s, v_inc_s;
    logic [9:0]  h_cur_s, v_cur_s;
    logic        h_bad_s, v_bad_s, err_s;
    logic        close_s, frame_bad_s;
    logic        vis_s, red_s, green_s;

    assign hs_edge_s = hs_s1_r & ~hs_prev_r;
    assign vs_edge_s = vs_s1_r & ~vs_prev_r;

    // Counts of the pixel currently in the input stage; a VS edge restarts
    // both counters and wins over a coincident HS edge.
    assign h_inc_s = {1'b0, h_cnt_r} + 11'd1;
    assign v_inc_s = {1'b0, v_cnt_r} + 11'd1;
    assign h_cur_s = (hs_edge_s | vs_edge_s) ? 10'd0 : sat_inc10(h_cnt_r);
    assign v_cur_s = vs_edge_s ? 10'd0 : (hs_edge_s ? sat_inc10(v_cnt_r) : v_cnt_r);

    // Line and frame lengths are judged on the count reached just before the
    // closing edge; the very first edge after reset has nothing to measure.
    assign h_bad_s = hs_edge_s & h_seen_r & (h_inc_s != 11'(H_TOTAL));
    assign v_bad_s = vs_edge_s & v_seen_r & (v_inc_s != 11'(V_TOTAL));
    assign err_s   = h_bad_s | v_bad_s;

    assign close_s     = vs_edge_s & v_seen_r;
    assign frame_bad_s = frame_err_r | err_s;

    assign vis_s   = (h_cur_s >= 10'(X_FIRST)) && (h_cur_s <= 10'(X_LAST)) &&
                     (v_cur_s >= 10'(Y_FIRST)) && (v_cur_s <= 10'(Y_LAST));
    assign red_s   = (r_s1_r == 4'hF) && (g_s1_r == 4'h0) && (b_s1_r == 4'h0);
    assign green_s = (r_s1_r == 4'h0) && (g_s1_r == 4'hF) && (b_s1_r == 4'h0);

    // Input capture, position recovery, timing checks, hit counting and frame close.
    always_ff @(posedge clk25) begin
        if (reset) begin
            hs_s1_r     <= 1'b0;
            vs_s1_r     <= 1'b0;
            hs_prev_r   <= 1'b0;
            vs_prev_r   <= 1'b0;
            r_s1_r      <= 4'h0;
            g_s1_r      <= 4'h0;
            b_s1_r      <= 4'h0;
            h_cnt_r     <= 10'd0;
            v_cnt_r     <= 10'd0;
            h_seen_r    <= 1'b0;
            v_seen_r    <= 1'b0;
            frame_err_r <= 1'b0;
            run_in_r    <= {COUNT_W{1'b0}};
            run_out_r   <= {COUNT_W{1'b0}};
            px_x        <= 10'd0;
            px_y        <= 10'd0;
            pxValid     <= 1'b0;
            insideHits  <= {COUNT_W{1'b0}};
            outsideHits <= {COUNT_W{1'b0}};
            frameDone   <= 1'b0;
            frameValid  <= 1'b0;
            hErr        <= 1'b0;
            vErr        <= 1'b0;
        end else begin
            hs_s1_r   <= (HS == SYNC_ACT);
            vs_s1_r   <= (VS == SYNC_ACT);
            hs_prev_r <= hs_s1_r;
            vs_prev_r <= vs_s1_r;
            r_s1_r    <= r;
            g_s1_r    <= g;
            b_s1_r    <= b;
            h_cnt_r   <= h_cur_s;
            v_cnt_r   <= v_cur_s;

            if (hs_edge_s) begin
                h_seen_r <= 1'b1;
            end else begin
                h_seen_r <= h_seen_r;
            end
            if (vs_edge_s) begin
                v_seen_r <= 1'b1;
            end else begin
                v_seen_r <= v_seen_r;
            end

            pxValid <= vis_s;
            px_x    <= vis_s ? (h_cur_s - 10'(X_FIRST)) : 10'd0;
            px_y    <= vis_s ? (v_cur_s - 10'(Y_FIRST)) : 10'd0;

            hErr      <= h_bad_s;
            vErr      <= v_bad_s;
            frameDone <= close_s;

            // An error seen on the closing edge still belongs to the closing frame.
            if (vs_edge_s) begin
                frame_err_r <= 1'b0;
            end else if (err_s) begin
                frame_err_r <= 1'b1;
            end else begin
                frame_err_r <= frame_err_r;
            end

            if (close_s) begin
                insideHits  <= run_in_r;
                outsideHits <= run_out_r;
                frameValid  <= ~frame_bad_s;
            end else begin
                insideHits  <= insideHits;
                outsideHits <= outsideHits;
                frameValid  <= frameValid;
            end

            // Every VS edge starts a fresh frame, so partial-frame hits never leak.
            if (vs_edge_s) begin
                run_in_r  <= {COUNT_W{1'b0}};
                run_out_r <= {COUNT_W{1'b0}};
            end else if (vis_s && red_s) begin
                run_in_r  <= sat_inc_cnt(run_in_r);
                run_out_r <= run_out_r;
            end else if (vis_s && green_s) begin
                run_in_r  <= run_in_r;
                run_out_r <= sat_inc_cnt(run_out_r);
            end else begin
                run_in_r  <= run_in_r;
                run_out_r <= run_out_r;
            end
        end
    end

    // Lock state machine; locked follows the state on the same edge as the error pulses.
    always_ff @(posedge clk25) begin
        if (reset) begin
            state_r   <= ST_UNLOCKED;
            acq_cnt_r <= 8'd0;
            locked    <= 1'b0;
        end else begin
            case (state_r)
                ST_UNLOCKED: begin
                    acq_cnt_r <= 8'd0;
                    locked    <= 1'b0;
                    if (vs_edge_s) begin
                        state_r <= ST_ACQUIRE;
                    end else begin
                        state_r <= ST_UNLOCKED;
                    end
                end
                ST_ACQUIRE: begin
                    if (err_s) begin
                        state_r   <= ST_ACQUIRE;
                        acq_cnt_r <= 8'd0;
                        locked    <= 1'b0;
                    end else if (close_s && !frame_err_r) begin
                        if ((acq_cnt_r + 8'd1) >= 8'(LOCK_FRAMES)) begin
                            state_r   <= ST_LOCKED;
                            acq_cnt_r <= 8'd0;
                            locked    <= 1'b1;
                        end else begin
                            state_r   <= ST_ACQUIRE;
                            acq_cnt_r <= acq_cnt_r + 8'd1;
                            locked    <= 1'b0;
                        end
                    end else begin
                        state_r   <= ST_ACQUIRE;
                        acq_cnt_r <= acq_cnt_r;
                        locked    <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    acq_cnt_r <= 8'd0;
                    if (err_s) begin
                        state_r <= ST_ACQUIRE;
                        locked  <= 1'b0;
                    end else begin
                        state_r <= ST_LOCKED;
                        locked  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_UNLOCKED;
                    acq_cnt_r <= 8'd0;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor using a shrunken raster
// (28 clocks x 20 lines, 16x12 visible) so many frames fit in a short run.
module tb_vga_frame_monitor;

    localparam int H_VIS = 16, H_SYNC = 4, H_BP = 4, H_TOTAL = 28;
    localparam int V_VIS = 12, V_SYNC = 2, V_BP = 3, V_TOTAL = 20;
    localparam int COUNT_W = 19;
    localparam int X0 = H_SYNC + H_BP;
    localparam int Y0 = V_SYNC + V_BP;

    logic clk25 = 1'b0;
    logic reset, HS, VS;
    logic [3:0] r, g, b;
    logic [9:0] px_x, px_y;
    logic pxValid, frameDone, frameValid, locked, hErr, vErr;
    logic [COUNT_W-1:0] insideHits, outsideHits;

    always #20 clk25 = ~clk25;

    vga_frame_monitor #(
        .H_VIS(H_VIS), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
        .V_VIS(V_VIS), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
        .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2), .COUNT_W(COUNT_W)
    ) dut (
        .clk25(clk25), .reset(reset), .HS(HS), .VS(VS), .r(r), .g(g), .b(b),
        .px_x(px_x), .px_y(px_y), .pxValid(pxValid),
        .insideHits(insideHits), .outsideHits(outsideHits),
        .frameDone(frameDone), .frameValid(frameValid), .locked(locked),
        .hErr(hErr), .vErr(vErr)
    );

    typedef enum int {EV_PIX, EV_HERR, EV_VERR, EV_FRAME} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int cyc; int x; int y; int ins; int outs; int fv; int lk;
    } ev_t;

    // One row = a VS edge (with the expected close of the previous frame) plus a frame body.
    typedef struct {
        int close; int verr; int ins; int outs; int fv; int lk;
        int nlines; int short_line; int mode; int rst_line;
    } row_t;

    ev_t  sb[$];
    row_t rows[12];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int v_off = 0;
    int drive_cyc = 0;
    bit zero_pending = 1'b0;

    // Count rising edges so expectations can carry the cycle they must appear in.
    always @(posedge clk25) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_t k, input int c, input int x, input int y,
                        input int ins, input int outs, input int fv, input int lk);
        ev_t e;
        e.kind = k; e.cyc = c; e.x = x; e.y = y;
        e.ins = ins; e.outs = outs; e.fv = fv; e.lk = lk;
        sb.push_back(e);
    endtask

    task automatic pop_expect(input ev_kind_t k, input string nm, output ev_t e, output bit ok);
        ok = 1'b0;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected output at cycle %0d, scoreboard empty", nm, cyc);
        end else begin
            e = sb.pop_front();
            check({nm, "_kind"}, int'(e.kind), int'(k));
            ok = (e.kind == k);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pxValid"}, int'(pxValid), 0);
        check({tag, "_px_x"}, int'(px_x), 0);
        check({tag, "_px_y"}, int'(px_y), 0);
        check({tag, "_insideHits"}, int'(insideHits), 0);
        check({tag, "_outsideHits"}, int'(outsideHits), 0);
        check({tag, "_frameDone"}, int'(frameDone), 0);
        check({tag, "_frameValid"}, int'(frameValid), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_hErr"}, int'(hErr), 0);
        check({tag, "_vErr"}, int'(vErr), 0);
    endtask

    // Drive one pixel; visible pixels get an expected coordinate two cycles later.
    task automatic drive(input int line, input int h, input bit hs_act, input bit vs_act,
                         input int mode, input bit rst);
        int vc, x, y;
        bit vis;
        @(negedge clk25);
        if (zero_pending) begin
            check_zero("after_mid_reset");
            zero_pending = 1'b0;
        end
        drive_cyc = cyc;
        vc  = line - v_off;
        vis = (h >= X0) && (h < X0 + H_VIS) && (vc >= Y0) && (vc < Y0 + V_VIS);
        x   = h - X0;
        y   = vc - Y0;
        reset = rst;
        HS = ~hs_act;
        VS = ~vs_act;
        {r, g, b} = 12'h000;
        case (mode)
            1: begin
                if (vis && y == 7 && x == 5) {r, g, b} = 12'hF00;
                else if (vis && y == 7 && x == 6) {r, g, b} = 12'hF01;
                else if (vis && y == 7 && x == 7) {r, g, b} = 12'hFF0;
                else {r, g, b} = 12'h000;
            end
            2: {r, g, b} = (vis && x == 0) ? 12'hF00 : 12'h0F0;
            default: {r, g, b} = 12'h000;
        endcase
        if (vis && !rst) push(EV_PIX, cyc + 2, x, y, 0, 0, 0, 0);
    endtask

    task automatic run_row(input row_t rw);
        int len;
        bit rst;
        v_off = 0;
        for (int ln = 0; ln < rw.nlines; ln++) begin
            len = (ln == rw.short_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                rst = (ln == rw.rst_line) && (h == 6);
                if (rst) v_off = ln;
                drive(ln, h, h < H_SYNC, ln < V_SYNC, rw.mode, rst);
                if (rst) zero_pending = 1'b1;
                if (ln == 0 && h == 0 && rw.close != 0) begin
                    if (rw.verr != 0) push(EV_VERR, drive_cyc + 2, 0, 0, 0, 0, 0, 0);
                    push(EV_FRAME, drive_cyc + 2, 0, 0, rw.ins, rw.outs, rw.fv, rw.lk);
                end
                if (h == 0 && rw.short_line >= 0 && ln == rw.short_line + 1)
                    push(EV_HERR, drive_cyc + 2, 0, 0, 0, 0, 0, 0);
            end
        end
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk25) begin : monitor
        ev_t e;
        bit ok;
        if (pxValid) begin
            pop_expect(EV_PIX, "pixel", e, ok);
            if (ok) begin
                check("px_x", int'(px_x), e.x);
                check("px_y", int'(px_y), e.y);
                check("px_latency", cyc, e.cyc);
            end
        end else begin
            check("px_zero_when_invalid", int'({px_x, px_y}), 0);
        end
        if (hErr) begin
            pop_expect(EV_HERR, "hErr", e, ok);
            if (ok) begin
                check("hErr_cycle", cyc, e.cyc);
                check("hErr_locked", int'(locked), 0);
            end
        end
        if (vErr) begin
            pop_expect(EV_VERR, "vErr", e, ok);
            if (ok) begin
                check("vErr_cycle", cyc, e.cyc);
                check("vErr_locked", int'(locked), 0);
            end
        end
        if (frameDone) begin
            pop_expect(EV_FRAME, "frameDone", e, ok);
            if (ok) begin
                check("frame_cycle", cyc, e.cyc);
                check("insideHits", int'(insideHits), e.ins);
                check("outsideHits", int'(outsideHits), e.outs);
                check("frameValid", int'(frameValid), e.fv);
                check("frame_locked", int'(locked), e.lk);
            end
        end
    end

    initial begin : watchdog
        repeat (40000) @(posedge clk25);
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stimulus
        //          close verr ins outs fv lk lines short mode rst
        rows[0]  = '{0, 0,  0,   0, 0, 0, 20, -1, 0, -1};  // first VS edge only opens a frame
        rows[1]  = '{1, 0,  0,   0, 1, 0, 20, -1, 0, -1};  // 1st good close, acquiring
        rows[2]  = '{1, 0,  0,   0, 1, 1, 20, -1, 1, -1};  // 2nd good close -> locked
        rows[3]  = '{1, 0,  1,   0, 1, 1, 20, -1, 2, -1};  // single red pixel frame
        rows[4]  = '{1, 0, 12, 180, 1, 1, 20, 10, 0, -1};  // green field, red column; next: short line
        rows[5]  = '{1, 0,  0,   0, 0, 0, 20, -1, 0, -1};  // frame with short line is invalid
        rows[6]  = '{1, 0,  0,   0, 1, 0, 20, -1, 0, -1};  // relock in progress
        rows[7]  = '{1, 0,  0,   0, 1, 1, 19, -1, 2, -1};  // relocked; next frame is one line short
        rows[8]  = '{1, 1, 12, 180, 0, 0, 20, -1, 0,  8};  // vErr close; reset mid-frame after
        rows[9]  = '{0, 0,  0,   0, 0, 0, 20, -1, 1, -1};  // first VS after reset: no close
        rows[10] = '{1, 0,  1,   0, 1, 0, 20, -1, 0, -1};
        rows[11] = '{1, 0,  0,   0, 1, 1,  2, -1, 0, -1};

        reset = 1'b1; HS = 1'b1; VS = 1'b1; r = 4'h0; g = 4'h0; b = 4'h0;
        repeat (3) @(negedge clk25);
        check_zero("reset");
        repeat (3) drive(-100, 0, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 12; i++) run_row(rows[i]);

        // Syncs held inactive long enough for the line counter to saturate;
        // the next HS edge must then report the bad line.
        repeat (1100) drive(-100, 0, 1'b0, 1'b0, 0, 1'b0);
        drive(-100, 0, 1'b1, 1'b0, 0, 1'b0);
        push(EV_HERR, drive_cyc + 2, 0, 0, 0, 0, 0, 0);
        repeat (3) drive(-100, 0, 1'b1, 1'b0, 0, 1'b0);
        repeat (6) drive(-100, 0, 1'b0, 1'b0, 0, 1'b0);

        repeat (4) @(negedge clk25);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
